// File: rtl/lc3_pkg.sv
// lc3_pkg: shared LC-3 constants (BR opcode, NZP bits/masks), resolver FSM state and taken test.
package lc3_pkg;
    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam int         N_BIT   = 2;
    localparam int         Z_BIT   = 1;
    localparam int         P_BIT   = 0;
    localparam logic [2:0] NZP_N   = 3'b100;
    localparam logic [2:0] NZP_Z   = 3'b010;
    localparam logic [2:0] NZP_P   = 3'b001;
    localparam logic [2:0] NZP_ALL = 3'b111;

    typedef enum logic [1:0] {IDLE, WAIT_CC, DONE} br_state_e;

    // BRnzp is unconditional even when no condition code is set.
    function automatic logic br_cond(input logic [2:0] nzp, input logic [2:0] psr);
        return (nzp == NZP_ALL) || |(nzp & psr);
    endfunction
endpackage

// File: rtl/br_target_add.sv
// br_target_add: pc plus sign-extended PCoffset9, wrapping modulo 2^PC_W.
module br_target_add #(
    parameter int PC_W = 16
) (
    input  logic [PC_W-1:0] pc,
    input  logic [8:0]      off9,
    output logic [PC_W-1:0] target
);
    assign target = pc + {{(PC_W-9){off9[8]}}, off9};
endmodule

// File: rtl/br_resolve.sv
// br_resolve: LC-3 conditional branch resolver (IDLE/WAIT_CC/DONE handshake FSM).
// Optional BR_STATS_EN adds saturating stat_total/stat_taken counters.
module br_resolve
    import lc3_pkg::*;
#(
    parameter int PC_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [PC_W-1:0] ir,
    input  logic [PC_W-1:0] pc,
    input  logic [2:0]      psr,
    input  logic            cc_pending,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            br_taken,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_pc
`ifdef BR_STATS_EN
    ,
    output logic [15:0]     stat_total,
    output logic [15:0]     stat_taken
`endif
);
    br_state_e       state;
    logic [2:0]      nzp_q;
    logic [PC_W-1:0] target;
    logic            is_br;

    br_target_add #(.PC_W(PC_W)) u_add (.pc(pc), .off9(ir[8:0]), .target(target));

    assign is_br          = ir[15:12] == OP_BR;
    assign in_ready       = state == IDLE;
    assign out_valid      = state == DONE;
    // Gated by rst so a reset landing on the handshake cycle cannot leak a redirect.
    assign redirect_valid = out_valid && out_ready && br_taken && rst;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            br_taken    <= 1'b0;
            redirect_pc <= '0;
            nzp_q       <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    nzp_q       <= ir[11:9];
                    redirect_pc <= is_br ? target : pc;
                    br_taken    <= is_br && !cc_pending && br_cond(ir[11:9], psr);
                    state       <= (is_br && cc_pending) ? WAIT_CC : DONE;
                end
                WAIT_CC: begin
                    br_taken <= br_cond(nzp_q, psr);
                    state    <= DONE;
                end
                DONE:    state <= out_ready ? IDLE : DONE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BR_STATS_EN
    logic is_br_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            is_br_q    <= 1'b0;
            stat_total <= '0;
            stat_taken <= '0;
        end else begin
            if (in_valid && in_ready) is_br_q <= is_br;
            if (out_valid && out_ready && is_br_q) begin
                stat_total <= (stat_total == 16'hFFFF) ? stat_total : stat_total + 16'd1;
                stat_taken <= (br_taken && stat_taken != 16'hFFFF) ? stat_taken + 16'd1 : stat_taken;
            end
        end
    end
`endif
endmodule

// File: doc/br_resolve.md
BR_RESOLVE -- requirements
Module: br_resolve

Interface
REQ-001 Parameter: PC_W, 16, width of PC, IR and target datapath.
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  upstream instruction available.
REQ-005 in_ready  output  1  block can accept an instruction.
REQ-006 ir  input  PC_W  instruction word; [15:12] opcode, [11:9] n/z/p mask, [8:0] PCoffset9.
REQ-007 pc  input  PC_W  incremented PC of the instruction.
REQ-008 psr  input  3  current N/Z/P condition codes, {N,Z,P}.
REQ-009 cc_pending  input  1  condition-code register is being written this cycle.
REQ-010 out_valid  output  1  resolution result available.
REQ-011 out_ready  input  1  downstream accepts result.
REQ-012 br_taken  output  1  resolved instruction is a taken branch.
REQ-013 redirect_valid  output  1  one-cycle fetch-redirect pulse.
REQ-014 redirect_pc  output  PC_W  branch target.

Function
REQ-015 FSM states SHALL be IDLE, WAIT_CC, DONE; in_ready=1 only in IDLE, out_valid=1 only in DONE.
REQ-016 IDLE: on in_valid&in_ready, ir and pc SHALL be captured.
REQ-017 Captured opcode != 4'b0000: next state DONE, br_taken=0, redirect_pc=pc.
REQ-018 Opcode 4'b0000 with cc_pending=0: psr sampled same cycle, next state DONE.
REQ-019 Opcode 4'b0000 with cc_pending=1: next state WAIT_CC; psr sampled in WAIT_CC, next state DONE.
REQ-020 Latency: accept cycle N -> out_valid at N+1 (no stall) or N+2 (WAIT_CC).
REQ-021 Taken = |(ir[11:9] & psr), except ir[11:9]=3'b111 SHALL be taken for any psr, including 3'b000.
REQ-022 ir[11:9]=3'b000 SHALL never be taken.
REQ-023 redirect_pc = pc + sign-extended ir[8:0], modulo 2^PC_W (wraps, no overflow flag).
REQ-024 DONE: outputs held stable until out_ready=1; then next state IDLE.
REQ-025 redirect_valid SHALL pulse exactly one cycle, the DONE cycle with out_ready=1 and br_taken=1.
REQ-026 Max throughput one instruction per two cycles; no instruction accepted in DONE, even if out_ready=1.
REQ-027 psr changes during DONE SHALL NOT affect br_taken.

Reset
REQ-028 rst=0 at posedge clk: state IDLE, out_valid=0, br_taken=0, redirect_valid=0, redirect_pc=0.
REQ-029 rst mid-operation (WAIT_CC or DONE) SHALL discard the in-flight instruction with no redirect_valid pulse.
REQ-030 in_ready SHALL read 1 in the first cycle after reset release.

Configuration
REQ-031 Macro BR_STATS_EN: when defined, outputs stat_total[15:0] and stat_taken[15:0] exist, counting BR instructions resolved and taken, incremented on the DONE handshake, saturating at 16'hFFFF, cleared by rst.
REQ-032 Without BR_STATS_EN: no counter ports or logic; all other behaviour identical.

Structure
REQ-033 Shared package lc3_pkg SHALL hold OP_BR opcode constant, NZP bit indices/masks and the FSM state enum.
REQ-034 One sub-module br_target_add (PC_W-bit pc + sign-extended offset) is natural; otherwise flat.

Verification
REQ-035 ir=16'h0A05 (BRnp +5), pc=16'h3001, psr=3'b100, cc_pending=0, out_ready=1 -> out_valid next cycle, br_taken=1, redirect_pc=16'h3006, one redirect_valid pulse.
REQ-036 ir=16'h05FF (BRz -1), pc=16'h3000, cc_pending=1, psr=3'b001 at accept then 3'b010 next cycle -> WAIT_CC, out_valid 2 cycles after accept, taken, redirect_pc=16'h2FFF.
REQ-037 ir=16'h0E00 (BRnzp), psr=3'b000 -> taken; ir=16'h0000 with psr=3'b111 -> not taken, no redirect_valid.
REQ-038 ir=16'h1021 (ADD) -> br_taken=0, redirect_valid never asserted; out_ready=0 for 3 cycles -> outputs held, in_ready=0.
REQ-039 ir=16'h00FF... wrap: ir=16'h0E01, pc=16'hFFFF -> redirect_pc=16'h0000; rst=0 during DONE -> no redirect pulse, in_ready=1 after release.
REQ-040 With BR_STATS_EN: 3 BR (2 taken) + 1 ADD -> stat_total=3, stat_taken=2; forced 16'hFFFF stays saturated.
